// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: shared state, mode constants and counter sizing for serial_twos_complement.
package twos_comp_pkg;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/serial_negate_cell.sv
// serial_negate_cell: one bit of LSB-first complement; two's mode copies up to the first 1 then inverts.
import twos_comp_pkg::*;
module serial_negate_cell (
    input  logic b,
    input  logic mode,
    input  logic seen_one,
    output logic out,
    output logic seen_one_nx
);
    always_comb begin
        out         = (mode == MODE_TWOS && !seen_one) ? b : ~b;
        seen_one_nx = seen_one | b;
    end
endmodule

// File: rtl/serial_twos_complement.sv
// serial_twos_complement: bit-serial one's/two's complement, one bit per clock, done pulse on completion.
// Define TWOS_COMP_OVF_EN to add the registered overflow output (negating the most negative value).
import twos_comp_pkg::*;
module serial_twos_complement #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y
`ifdef TWOS_COMP_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = cnt_w(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             seen_one;
    logic             out_bit;
    logic             seen_one_nx;
    logic             last;

    serial_negate_cell u_cell (
        .b           (shreg[0]),
        .mode        (mode_q),
        .seen_one    (seen_one),
        .out         (out_bit),
        .seen_one_nx (seen_one_nx)
    );

    always_comb begin
        res_nx = {out_bit, res[WIDTH-1:1]};
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            res      <= '0;
            cnt      <= '0;
            mode_q   <= MODE_ONES;
            seen_one <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Y        <= '0;
`ifdef TWOS_COMP_OVF_EN
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shreg    <= A;
                    mode_q   <= mode;
                    cnt      <= '0;
                    seen_one <= 1'b0;
                    busy     <= 1'b1;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    shreg    <= shreg >> 1;
                    res      <= res_nx;
                    seen_one <= seen_one_nx;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Y     <= res_nx;
`ifdef TWOS_COMP_OVF_EN
                        // MSB set with no lower 1 seen means the operand was 100...0
                        overflow <= (mode_q == MODE_TWOS) && shreg[0] && !seen_one;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
